// File: rtl/sc_stream_ctr.sv
// Stochastic-to-binary back end: applies an SC operator to generator bitstreams,
// counts ones and stream length, and hands the result over a valid/ready handshake.
module sc_stream_ctr #(
    parameter int unsigned NUM_INPUTS = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            op,
    input  logic [CNT_WIDTH-1:0]  len_limit,
    input  logic [NUM_INPUTS-1:0] Xs,
    input  logic                  done,
    output logic                  gen_rst_n,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  result,
    output logic [CNT_WIDTH-1:0]  length,
    output logic                  term,
    output logic                  sat,
    output logic                  result_valid,
    input  logic                  result_ready
);

    typedef enum logic [1:0] {StIdle, StRun, StHold} state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_result, w_result_nxt;
    logic [CNT_WIDTH-1:0] r_length, w_length_nxt;
    logic [CNT_WIDTH-1:0] r_limit, w_limit_nxt;
    logic [1:0]           r_op, w_op_nxt;
    logic                 r_term, w_term_nxt;
    logic                 r_sat, w_sat_nxt;
    logic                 r_gen_rst_n, w_gen_rst_n_nxt;
    logic                 w_bit;
    logic [CNT_WIDTH:0]   w_len_inc;

    always_comb begin
        case (r_op)
            2'd0:    w_bit = &Xs;
            2'd1:    w_bit = |Xs;
            2'd2:    w_bit = Xs[0] ^ Xs[1];
            default: w_bit = Xs[0];
        endcase
    end

    // One bit wider so the limit compare cannot alias when length sits at its maximum.
    assign w_len_inc = {1'b0, r_length} + (CNT_WIDTH + 1)'(1);

    always_comb begin
        w_state_nxt  = r_state;
        w_result_nxt = r_result;
        w_length_nxt = r_length;
        w_limit_nxt  = r_limit;
        w_op_nxt     = r_op;
        w_term_nxt   = r_term;
        w_sat_nxt    = r_sat;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_nxt  = StRun;
                    w_result_nxt = '0;
                    w_length_nxt = '0;
                    w_term_nxt   = 1'b0;
                    w_sat_nxt    = 1'b0;
                    w_op_nxt     = op;
                    w_limit_nxt  = len_limit;
                end
            end
            StRun: begin
                if (abort) begin
                    w_state_nxt = StIdle;
                end else if (done) begin
                    w_state_nxt = StHold;
                    w_term_nxt  = 1'b0;
                end else begin
                    if (&r_length) begin
                        w_sat_nxt = 1'b1;
                    end else begin
                        w_length_nxt = w_len_inc[CNT_WIDTH-1:0];
                    end
                    if (w_bit) begin
                        if (&r_result) begin
                            w_sat_nxt = 1'b1;
                        end else begin
                            w_result_nxt = r_result + CNT_WIDTH'(1);
                        end
                    end
                    if ((r_limit != '0) && (w_len_inc == {1'b0, r_limit})) begin
                        w_state_nxt = StHold;
                        w_term_nxt  = 1'b1;
                    end
                end
            end
            StHold: begin
                if (result_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
        // Generator is released only for cycles spent in RUN.
        w_gen_rst_n_nxt = (w_state_nxt == StRun);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_result    <= '0;
            r_length    <= '0;
            r_limit     <= '0;
            r_op        <= 2'd0;
            r_term      <= 1'b0;
            r_sat       <= 1'b0;
            r_gen_rst_n <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_result    <= w_result_nxt;
            r_length    <= w_length_nxt;
            r_limit     <= w_limit_nxt;
            r_op        <= w_op_nxt;
            r_term      <= w_term_nxt;
            r_sat       <= w_sat_nxt;
            r_gen_rst_n <= w_gen_rst_n_nxt;
        end
    end

    assign gen_rst_n    = r_gen_rst_n;
    assign busy         = (r_state == StRun);
    assign result_valid = (r_state == StHold);
    assign result       = r_result;
    assign length       = r_length;
    assign term         = r_term;
    assign sat          = r_sat;

endmodule

// File: tb/tb_sc_stream_ctr.sv
// Randomized and directed bench for sc_stream_ctr; expected counts come from a
// bit-level model that sums the operator over the driven stream.
module tb_sc_stream_ctr;
    localparam int W  = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0, abort = 1'b0, done = 1'b0, result_ready = 1'b0;
    logic [1:0]    op = 2'd0;
    logic [W-1:0]  len_limit = '0;
    logic [1:0]    xs = 2'b00;
    logic          gen_rst_n, busy, term, sat, result_valid;
    logic [W-1:0]  result, length;

    logic          s_start = 1'b0, s_abort = 1'b0, s_done = 1'b0, s_ready = 1'b0;
    logic [1:0]    s_op = 2'd3;
    logic [SW-1:0] s_limit = '0;
    logic [2:0]    s_xs = 3'b000;
    logic          s_gen_rst_n, s_busy, s_term, s_sat, s_valid;
    logic [SW-1:0] s_result, s_length;

    int errors = 0;
    int checks = 0;
    logic [1:0] stim [0:511];

    sc_stream_ctr #(.NUM_INPUTS(2), .CNT_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op),
        .len_limit(len_limit), .Xs(xs), .done(done), .gen_rst_n(gen_rst_n),
        .busy(busy), .result(result), .length(length), .term(term), .sat(sat),
        .result_valid(result_valid), .result_ready(result_ready)
    );

    sc_stream_ctr #(.NUM_INPUTS(3), .CNT_WIDTH(SW)) dut_s (
        .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .op(s_op),
        .len_limit(s_limit), .Xs(s_xs), .done(s_done), .gen_rst_n(s_gen_rst_n),
        .busy(s_busy), .result(s_result), .length(s_length), .term(s_term), .sat(s_sat),
        .result_valid(s_valid), .result_ready(s_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_count(input int k, input logic [1:0] o);
        int c = 0;
        for (int i = 0; i < k; i++) begin
            logic [1:0] b = stim[i];
            case (o)
                2'd0: if (b == 2'b11) c++;
                2'd1: if (b != 2'b00) c++;
                2'd2: if (b[0] != b[1]) c++;
                default: if (b[0]) c++;
            endcase
        end
        return c;
    endfunction

    task automatic fill_multiply();
        for (int i = 0; i < 512; i++) stim[i] = {((i / 16) % 16) < 4, (i % 16) < 8};
    endtask

    // Full run through the handshake; the next run may start in the following cycle.
    task automatic do_run(input string name, input int n, input logic [1:0] o, input int lim);
        bit exp_term;
        int k, exp_res;
        exp_term = (lim != 0) && (lim <= n);
        k = exp_term ? lim : n;
        exp_res = model_count(k, o);
        start = 1'b1; op = o; len_limit = W'(lim);
        tick();
        start = 1'b0;
        op = ~o; len_limit = W'(3);
        checks++;
        if (busy !== 1'b1 || gen_rst_n !== 1'b1 || result_valid !== 1'b0)
            $display("FAIL %s_enter: busy=%b gen_rst_n=%b valid=%b, required 1 1 0",
                     name, busy, gen_rst_n, result_valid);
        for (int i = 0; i < k; i++) begin
            xs = stim[i];
            if (i == k - 1) begin
                checks++;
                if (result_valid !== 1'b0)
                    $display("FAIL %s_early: valid=%b before last bit, required 0",
                             name, result_valid);
            end
            tick();
        end
        if (!exp_term) begin
            xs = 2'($urandom); done = 1'b1;
            tick();
            done = 1'b0;
        end
        checks++;
        if (result_valid !== 1'b1 || result !== W'(exp_res) || length !== W'(k) ||
            term !== exp_term || sat !== 1'b0 || gen_rst_n !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: valid=%b result=%0d length=%0d term=%b sat=%b grn=%b busy=%b, required 1 %0d %0d %b 0 0 0",
                     name, result_valid, result, length, term, sat, gen_rst_n, busy,
                     exp_res, k, exp_term);
        end
        done = 1'b1; abort = 1'b1;
        tick();
        done = 1'b0; abort = 1'b0; result_ready = 1'b1;
        checks++;
        if (result_valid !== 1'b1 || length !== W'(k))
            $display("FAIL %s_hold: valid=%b length=%0d, required 1 %0d", name, result_valid, length, k);
        tick();
        result_ready = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || gen_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL %s_xfer: valid=%b busy=%b grn=%b, required 0 0 0",
                     name, result_valid, busy, gen_rst_n);
        end
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if (gen_rst_n !== 0 || busy !== 0 || result_valid !== 0 || result !== 0 ||
            length !== 0 || term !== 0 || sat !== 0 || s_valid !== 0 || s_sat !== 0) begin
            errors++;
            $display("FAIL reset: grn=%b busy=%b valid=%b result=%0d length=%0d term=%b sat=%b, required all 0",
                     gen_rst_n, busy, result_valid, result, length, term, sat);
        end
        #3 rst = 1'b0;
        tick();
    endtask

    task automatic test_multiply();
        fill_multiply();
        if (model_count(256, 2'd0) != 32) $display("note: multiply stream model gives %0d", model_count(256, 2'd0));
        do_run("multiply", 256, 2'd0, 0);
    endtask

    task automatic test_corr_sub();
        for (int i = 0; i < 512; i++) stim[i] = {i < 72, i < 200};
        do_run("corr_sub", 256, 2'd2, 0);
    endtask

    task automatic test_early_term();
        fill_multiply();
        do_run("early_term", 256, 2'd0, 16);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 8; r++) begin
            int n, lim;
            n = $urandom_range(300, 20);
            lim = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(n + 10, 1);
            for (int i = 0; i < 512; i++) stim[i] = 2'($urandom);
            do_run($sformatf("random%0d", r), n, 2'($urandom), lim);
        end
    endtask

    task automatic test_done_vs_limit();
        int exp_res;
        for (int i = 0; i < 512; i++) stim[i] = 2'($urandom);
        exp_res = model_count(7, 2'd1);
        start = 1'b1; op = 2'd1; len_limit = W'(8);
        tick();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            xs = stim[i]; done = (i == 7);
            tick();
        end
        done = 1'b0;
        checks++;
        if (result_valid !== 1 || length !== W'(7) || result !== W'(exp_res) || term !== 0) begin
            errors++;
            $display("FAIL done_vs_limit: valid=%b length=%0d result=%0d term=%b, required 1 7 %0d 0",
                     result_valid, length, result, term, exp_res);
        end
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int exp_res;
        fill_multiply();
        exp_res = model_count(10, 2'd0);
        start = 1'b1; op = 2'd0; len_limit = W'(10);
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            xs = stim[i];
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            start = c[0]; abort = ~c[0]; xs = 2'($urandom);
            tick();
            checks++;
            if (result_valid !== 1 || busy !== 0 || gen_rst_n !== 0 || result !== W'(exp_res) ||
                length !== W'(10) || term !== 1) begin
                errors++;
                $display("FAIL backpressure%0d: valid=%b busy=%b grn=%b result=%0d length=%0d term=%b, required 1 0 0 %0d 10 1",
                         c, result_valid, busy, gen_rst_n, result, length, term, exp_res);
            end
        end
        start = 1'b0; abort = 1'b0; result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checks++;
        if (result_valid !== 0 || busy !== 0) begin
            errors++;
            $display("FAIL bp_release: valid=%b busy=%b, required 0 0", result_valid, busy);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1 || gen_rst_n !== 1) begin
            errors++;
            $display("FAIL bp_restart: busy=%b grn=%b, required 1 1", busy, gen_rst_n);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_abort();
        start = 1'b1; op = 2'd3; len_limit = '0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            xs = 2'($urandom);
            tick();
        end
        abort = 1'b1; xs = 2'b11;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 0 || result_valid !== 0 || gen_rst_n !== 0) begin
            errors++;
            $display("FAIL abort: busy=%b valid=%b grn=%b, required 0 0 0", busy, result_valid, gen_rst_n);
        end
        for (int c = 0; c < 4; c++) begin
            done = 1'b1;
            tick();
            checks++;
            if (result_valid !== 0 || busy !== 0) begin
                errors++;
                $display("FAIL abort_idle%0d: valid=%b busy=%b, required 0 0", c, result_valid, busy);
            end
        end
        done = 1'b0;
    endtask

    task automatic test_saturation();
        s_start = 1'b1; s_op = 2'd3; s_limit = '0;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            s_xs = {2'($urandom), 1'b1};
            tick();
        end
        s_done = 1'b1;
        tick();
        s_done = 1'b0;
        checks++;
        if (s_valid !== 1 || s_result !== 4'd15 || s_length !== 4'd15 || s_sat !== 1 || s_term !== 0) begin
            errors++;
            $display("FAIL saturation: valid=%b result=%0d length=%0d sat=%b term=%b, required 1 15 15 1 0",
                     s_valid, s_result, s_length, s_sat, s_term);
        end
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0; s_start = 1'b1;
        tick();
        s_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_xs = (i == 1) ? 3'b110 : 3'b111;
            tick();
        end
        s_done = 1'b1;
        tick();
        s_done = 1'b0;
        checks++;
        if (s_valid !== 1 || s_result !== 4'd2 || s_length !== 4'd3 || s_sat !== 0) begin
            errors++;
            $display("FAIL sat_clear: valid=%b result=%0d length=%0d sat=%b, required 1 2 3 0",
                     s_valid, s_result, s_length, s_sat);
        end
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
    endtask

    task automatic test_reset_midrun();
        fill_multiply();
        start = 1'b1; op = 2'd0; len_limit = '0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            xs = stim[i];
            tick();
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (gen_rst_n !== 0 || busy !== 0 || result_valid !== 0 || result !== 0 ||
            length !== 0 || term !== 0 || sat !== 0) begin
            errors++;
            $display("FAIL reset_midrun: grn=%b busy=%b valid=%b result=%0d length=%0d term=%b sat=%b, required all 0",
                     gen_rst_n, busy, result_valid, result, length, term, sat);
        end
        #1 rst = 1'b0;
        tick();
        do_run("rerun", 256, 2'd0, 0);
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_corr_sub();
        test_early_term();
        test_back_to_back();
        test_done_vs_limit();
        test_backpressure();
        test_abort();
        test_saturation();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sc_stream_ctr.md
# sc_stream_ctr

Stochastic-to-binary back end for the CAPE bitstream generators (`cape`, `cape_corr`, `cape_ET`, `cape_ET_corr`). It consumes the generator's `Xs` bitstreams and `done` pulse, applies one SC operator per cycle, and counts ones and stream length. It terminates on generator `done`, on a programmable length limit, or on abort. The result is presented through a valid/ready handshake. While idle or holding a result, the block keeps the generator in reset through `gen_rst_n`, so each run starts at count 0.

## Interface
Parameters:
- NUM_INPUTS, default 2: number of bitstreams in `Xs`; must be ≥ 2.
- CNT_WIDTH, default 16: width of the ones counter and the length counter.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a run; sampled in IDLE only.
- abort  input  1  cancel a run; sampled in RUN only.
- op  input  2  operator: 0 AND-reduce of all Xs (multiply), 1 OR-reduce, 2 Xs[0]^Xs[1] (correlated |a−b|), 3 Xs[0] pass-through.
- len_limit  input  CNT_WIDTH  bit budget for early termination; 0 = unlimited. Sampled with start.
- Xs  input  NUM_INPUTS  generator bitstreams.
- done  input  1  generator end-of-stream pulse.
- gen_rst_n  output  1  active-low reset to the generator; registered.
- busy  output  1  high in RUN.
- result  output  CNT_WIDTH  ones count.
- length  output  CNT_WIDTH  bits counted.
- term  output  1  0 = ended by done, 1 = ended by len_limit.
- sat  output  1  ones or length counter saturated.
- result_valid  output  1  result held.
- result_ready  input  1  consumer accepts.

## Operation
- States: IDLE, RUN, HOLD. Reset → IDLE.
- IDLE:
  - gen_rst_n=0, busy=0, result_valid=0.
  - On start: clear the counters, sat and term. Latch op and len_limit. Go to RUN.
- RUN: gen_rst_n=1, busy=1. Each cycle, in priority order:
  1. abort → IDLE. No result; counters keep stale values and are don't-care.
  2. done → HOLD, term=0. This cycle's Xs is not counted.
  3. Otherwise count the bit: length+=1, and result+=f(op,Xs).
  4. If len_limit≠0 and length+1==len_limit after this count → HOLD, term=1.
- Saturation: each counter stops at 2^CNT_WIDTH−1; sat sets and stays set until the next start.
- HOLD:
  - gen_rst_n=0, result_valid=1; result, length, term and sat are stable.
  - On result_ready → IDLE.
  - start and abort are ignored.
- op and len_limit changes during RUN or HOLD have no effect.
- Xs bits above index 1 are ignored for op 2 and 3.

## Timing
- Reset values: gen_rst_n=0, busy=0, result_valid=0, result=0, length=0, term=0, sat=0.
- start sampled at edge T0 → RUN in cycle T0+1, with gen_rst_n=1 from that cycle. The generator emits bit 0 in that same cycle; it is counted at edge T0+1.
- A full generator stream of N bits ends with done high in the cycle after the last bit. The result is valid in the cycle after done is sampled, with length=N.
- Limit path: result_valid rises in the cycle after the edge that counted bit number len_limit.
- Handshake:
  - result_valid and result_ready both high at an edge → transfer; next cycle is IDLE with result_valid=0.
  - result_valid never drops without a transfer, except on rst.
- Back-to-back runs: earliest next start is sampled in the IDLE cycle after the transfer. The generator sees at least one low gen_rst_n cycle between runs.
- done and limit reached in the same cycle: done wins, the bit is not counted, term=0.
- done or abort while in IDLE or HOLD: ignored.
- rst mid-RUN or mid-HOLD: immediate return to IDLE with reset values; any pending result is lost.

## Test plan
- Multiply: NUM_INPUTS=2, CNT_WIDTH=16, `cape` WIDTH=4, Bxs={8,4}, op=0, len_limit=0 → length=256, result=32, term=0, sat=0.
- Correlated subtract: `cape_corr` WIDTH=8, Bxs={200,72}, op=2 → length=256, result=128.
- Early termination: same as the multiply case with len_limit=16 → result_valid rises 16 count cycles after RUN entry; length=16, term=1; gen_rst_n=0 during HOLD.
- Handshake/backpressure: hold result_ready=0 for 10 cycles in HOLD, with start and abort pulsed → outputs stable, no new run. Then ready=1 → IDLE next cycle; a new start is accepted the cycle after.
- Saturation and abort: CNT_WIDTH=4, op=3, Xs[0]=1, stream of 40 bits → result=15, length=15, sat=1. A separate run aborted at bit 5 → IDLE with no result_valid pulse.
- Reset: assert rst mid-RUN at bit 100 → all outputs at reset values, combinationally with rst. A rerun after release gives the full correct count.
